hit_histogram: RTL

- Accumulates detector hit events into per-channel count histograms: 128 bins on the Y axis and 128 bins on the X axis.
- Uses fixed-length acquisition frames. Each completed frame is frozen into a readout bank and handed to the USB controller stage.
- Raises start_sending to the USB controller and serves it data_yaxis/data_xaxis, combinationally addressed by the controller's read indices.
- Sits directly upstream of the USB controller and consumes its command output.

---
 rtl/hit_histogram.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hit_histogram.sv
// Double-banked X/Y hit histogram: one bank accumulates a fixed-length frame
// while the other bank is frozen and served combinationally to the USB controller.
module hit_histogram #(
    parameter int unsigned NUM_BINS     = 128,
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned START_HOLD   = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hit_valid,
    input  logic [6:0]  hit_xaxis,
    input  logic [6:0]  hit_yaxis,
    input  logic [15:0] command,
    input  logic [6:0]  read_index_yaxis,
    input  logic [6:0]  read_index_xaxis,
    output logic [15:0] data_yaxis,
    output logic [15:0] data_xaxis,
    output logic        start_sending,
    output logic        acquiring,
    output logic [15:0] frame_count,
    output logic [15:0] dropped_hits,
    output logic        saturated
);

    localparam int unsigned IW = $clog2(NUM_BINS);
    localparam int unsigned FW = $clog2(FRAME_CYCLES);
    localparam int unsigned HW = $clog2(START_HOLD + 1);
    localparam logic [COUNT_WIDTH-1:0] BIN_MAX = '1;
    localparam logic [15:0] CMD_RUN   = 16'd1;
    localparam logic [15:0] CMD_STOP  = 16'd2;
    localparam logic [15:0] CMD_CLEAR = 16'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACQUIRE,
        S_SWAP,
        S_CLEAR_ALL
    } state_e;

    state_e          state_q, state_d;
    logic            bank_sel_q, bank_sel_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   clr_q, clr_d;
    logic [15:0]     cmd_s1_q, cmd_s2_q, cmd_prev_q;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [15:0]     dropped_q, dropped_d;
    logic            sat_q, sat_d;

    logic [COUNT_WIDTH-1:0] ybank_q [2][NUM_BINS];
    logic [COUNT_WIDTH-1:0] xbank_q [2][NUM_BINS];

    logic cmd_change, do_run, do_stop, do_clear_all, hit_full;

    assign cmd_change   = (cmd_s2_q != cmd_prev_q);
    assign do_run       = cmd_change && (cmd_s2_q == CMD_RUN);
    assign do_stop      = cmd_change && (cmd_s2_q == CMD_STOP);
    assign do_clear_all = cmd_change && (cmd_s2_q == CMD_CLEAR);
    assign hit_full     = (ybank_q[bank_sel_q][hit_yaxis] == BIN_MAX) ||
                          (xbank_q[bank_sel_q][hit_xaxis] == BIN_MAX);

    always_comb begin
        state_d       = state_q;
        bank_sel_d    = bank_sel_q;
        frame_d       = '0;
        clr_d         = '0;
        frame_count_d = frame_count_q;
        dropped_d     = dropped_q;
        sat_d         = sat_q;
        hold_d        = (hold_q != '0) ? hold_q - 1'b1 : hold_q;

        if (hit_valid && (state_q != S_ACQUIRE) && (dropped_q != '1)) begin
            dropped_d = dropped_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (do_run) begin
                    state_d   = S_CLEAR;
                    dropped_d = '0;
                end else if (do_clear_all) begin
                    state_d = S_CLEAR_ALL;
                end
            end
            S_CLEAR: begin
                if (do_stop)                      state_d = S_IDLE;
                else if (do_clear_all)            state_d = S_CLEAR_ALL;
                else if (clr_q == IW'(NUM_BINS - 1)) state_d = S_ACQUIRE;
                else                              clr_d   = clr_q + 1'b1;
            end
            S_ACQUIRE: begin
                frame_d = frame_q + 1'b1;
                if (hit_valid && hit_full) sat_d = 1'b1;
                if (do_stop)                              state_d = S_IDLE;
                else if (do_clear_all)                    state_d = S_CLEAR_ALL;
                else if (frame_q == FW'(FRAME_CYCLES - 1)) state_d = S_SWAP;
            end
            S_SWAP: begin
                if (do_stop) begin
                    state_d = S_IDLE;
                end else begin
                    bank_sel_d    = ~bank_sel_q;
                    frame_count_d = frame_count_q + 1'b1;
                    hold_d        = HW'(START_HOLD);
                    state_d       = S_CLEAR;
                end
            end
            S_CLEAR_ALL: begin
                if (clr_q == IW'(NUM_BINS - 1)) state_d = S_IDLE;
                else                            clr_d   = clr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_CLEAR_ALL) && (state_q != S_CLEAR_ALL)) sat_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            bank_sel_q    <= 1'b0;
            frame_q       <= '0;
            hold_q        <= '0;
            clr_q         <= '0;
            cmd_s1_q      <= '0;
            cmd_s2_q      <= '0;
            cmd_prev_q    <= '0;
            frame_count_q <= '0;
            dropped_q     <= '0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            frame_q       <= frame_d;
            hold_q        <= hold_d;
            clr_q         <= clr_d;
            cmd_s1_q      <= command;
            cmd_s2_q      <= cmd_s1_q;
            cmd_prev_q    <= cmd_s2_q;
            frame_count_q <= frame_count_d;
            dropped_q     <= dropped_d;
            sat_q         <= sat_d;
        end
    end

    // Bins are updated in place rather than via a full-array next-state copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ybank_q <= '{default: '0};
            xbank_q <= '{default: '0};
        end else if (state_q == S_CLEAR) begin
            ybank_q[bank_sel_q][clr_q] <= '0;
            xbank_q[bank_sel_q][clr_q] <= '0;
        end else if (state_q == S_CLEAR_ALL) begin
            ybank_q[0][clr_q] <= '0;
            ybank_q[1][clr_q] <= '0;
            xbank_q[0][clr_q] <= '0;
            xbank_q[1][clr_q] <= '0;
        end else if ((state_q == S_ACQUIRE) && hit_valid) begin
            if (ybank_q[bank_sel_q][hit_yaxis] != BIN_MAX)
                ybank_q[bank_sel_q][hit_yaxis] <= ybank_q[bank_sel_q][hit_yaxis] + 1'b1;
            if (xbank_q[bank_sel_q][hit_xaxis] != BIN_MAX)
                xbank_q[bank_sel_q][hit_xaxis] <= xbank_q[bank_sel_q][hit_xaxis] + 1'b1;
        end
    end

    assign data_yaxis    = 16'(ybank_q[~bank_sel_q][read_index_yaxis]);
    assign data_xaxis    = 16'(xbank_q[~bank_sel_q][read_index_xaxis]);
    assign start_sending = (hold_q != '0);
    assign acquiring     = (state_q == S_ACQUIRE);
    assign frame_count   = frame_count_q;
    assign dropped_hits  = dropped_q;
    assign saturated     = sat_q;

endmodule
